// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU issue/writeback stage.
package alu_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_N_DEF  = 8;
    localparam int unsigned RA_W_DEF   = $clog2(REG_N_DEF);

    // ALU control encodings; any op with bit 2 set is reserved.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_op_e;

    // Instruction held in the EX pipeline register.
    typedef struct packed {
        logic [2:0]            op;
        logic [RA_W_DEF-1:0]   rd;
        logic [RA_W_DEF-1:0]   rs1;
        logic [RA_W_DEF-1:0]   rs2;
        logic                  use_imm;
        logic [DATA_W_DEF-1:0] imm;
    } ex_t;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two operand read ports, one debug read port, one write port.
// r0 is never written, so it always reads zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_N  = REG_N_DEF,
    localparam int unsigned RA_W  = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RA_W-1:0]   raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [RA_W-1:0]   raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [RA_W-1:0]   dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] rf_q [REG_N];
    logic [DATA_W-1:0] rf_d [REG_N];

    // Next-state: single write port, writes to r0 dropped.
    always_comb begin
        rf_d = rf_q;
        if (we && (waddr != '0)) begin
            rf_d[waddr] = wdata;
        end
        rf_d[0] = '0;
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Combinational read ports.
    always_comb begin
        rdata_a   = rf_q[raddr_a];
        rdata_b   = rf_q[raddr_b];
        dbg_rdata = rf_q[dbg_raddr];
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage wrapped around an external combinational ALU.
// EX holds the issued instruction and drives the ALU; WB captures the result and
// commits it to the register file when the downstream sink accepts it.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_N  = REG_N_DEF,
    localparam int unsigned RA_W  = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [RA_W-1:0]   in_rs2,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_q,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [RA_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    input  logic [RA_W-1:0]   dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    ex_t               ex_q, ex_d;
    logic              ex_valid_q, ex_valid_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              wb_adv;
    logic              commit;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic [DATA_W-1:0] op_a, op_b;

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a   (ex_q.rs1),
        .rdata_a   (rf_a),
        .raddr_b   (ex_q.rs2),
        .rdata_b   (rf_b),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .we        (commit),
        .waddr     (wb_rd_q),
        .wdata     (wb_data_q)
    );

    // Handshake, operand fetch with forwarding from the pending WB result, ALU drive.
    // Forwarding uses the current WB value, which is also what commits this edge.
    always_comb begin
        wb_adv   = !wb_valid_q || wb_ready;
        in_ready = !ex_valid_q || wb_adv;
        commit   = wb_valid_q && wb_ready;

        op_a = rf_a;
        if (wb_valid_q && (wb_rd_q == ex_q.rs1) && (ex_q.rs1 != '0)) begin
            op_a = wb_data_q;
        end
        op_b = rf_b;
        if (wb_valid_q && (wb_rd_q == ex_q.rs2) && (ex_q.rs2 != '0)) begin
            op_b = wb_data_q;
        end
        if (ex_q.use_imm) begin
            op_b = ex_q.imm;
        end

        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (ex_valid_q) begin
            alu_a    = op_a;
            alu_b    = op_b;
            alu_ctrl = ex_q.op;
        end
    end

    // Next-state for EX and WB pipeline registers.
    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;

        if (in_ready) begin
            ex_valid_d = in_valid;
            if (in_valid) begin
                ex_d.op      = in_op;
                ex_d.rd      = in_rd;
                ex_d.rs1     = in_rs1;
                ex_d.rs2     = in_rs2;
                ex_d.use_imm = in_use_imm;
                ex_d.imm     = in_imm;
            end
        end

        if (wb_adv) begin
            wb_valid_d = 1'b0;
            // Reserved ops (bit 2 set) retire silently without a WB result.
            if (ex_valid_q && !ex_q.op[2]) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = ex_q.rd;
                wb_data_d  = alu_q;
            end
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU attached.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd, in_rs1, in_rs2;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [31:0] alu_a, alu_b, alu_q;
    logic [2:0]  alu_ctrl;
    logic        wb_valid, wb_ready;
    logic [2:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    typedef struct packed {
        logic [2:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_q      (alu_q),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    // Behavioural ALU standing in for the real one.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_q = alu_a + alu_b;
            3'b001:  alu_q = alu_a - alu_b;
            3'b010:  alu_q = alu_a & alu_b;
            3'b011:  alu_q = alu_a | alu_b;
            default: alu_q = 32'h0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got rd %0d data 0x%08h expected none", wb_rd,
                         wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_rd", {29'h0, wb_rd}, {29'h0, e.rd});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    // Offer one instruction; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic use_imm, input logic [31:0] imm,
                         input logic [31:0] exp_data);
        int n;
        in_valid   = 1'b1;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = use_imm;
        in_imm     = imm;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready 0 expected 1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (!op[2]) exp_q.push_back('{rd: rd, data: exp_data});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || wb_valid) && n < 50);
        if (exp_q.size() != 0 || wb_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic chk_reg(input logic [2:0] addr, input logic [31:0] exp);
        dbg_raddr = addr;
        #1;
        chk($sformatf("dbg_r%0d", addr), dbg_rdata, exp);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_ctrl", {29'h0, alu_ctrl}, 32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_wb_rd", {29'h0, wb_rd}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        for (int a = 0; a < 8; a++) chk_reg(3'(a), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = 3'b000;
        in_rd      = 3'd0;
        in_rs1     = 3'd0;
        in_rs2     = 3'd0;
        in_use_imm = 1'b0;
        in_imm     = 32'h0;
        wb_ready   = 1'b1;
        dbg_raddr  = 3'd0;

        repeat (2) @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back dependent adds exercise WB->EX forwarding.
        issue(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, 32'd5);
        issue(3'b000, 3'd2, 3'd1, 3'd0, 1'b1, 32'd3, 32'd8);
        drain();
        chk_reg(3'd1, 32'd5);
        chk_reg(3'd2, 32'd8);

        // Wrap-around subtract, then logic ops on the result.
        @(posedge clk); #1;
        issue(3'b001, 3'd3, 3'd0, 3'd0, 1'b1, 32'd1, 32'hFFFF_FFFF);
        issue(3'b010, 3'd4, 3'd3, 3'd0, 1'b1, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
        issue(3'b011, 3'd5, 3'd4, 3'd2, 1'b0, 32'h0, 32'h0F0F_0F0F);
        drain();
        chk_reg(3'd3, 32'hFFFF_FFFF);
        chk_reg(3'd5, 32'h0F0F_0F0F);

        // Backpressure: two accepted, third held until the sink opens.
        @(posedge clk); #1;
        wb_ready = 1'b0;
        fork
            begin
                issue(3'b000, 3'd6, 3'd1, 3'd0, 1'b1, 32'd10, 32'd15);
                issue(3'b001, 3'd7, 3'd6, 3'd2, 1'b0, 32'h0, 32'd7);
                issue(3'b011, 3'd1, 3'd7, 3'd0, 1'b1, 32'h100, 32'h107);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
                chk("bp_wb_valid", {31'h0, wb_valid}, 32'h1);
                @(posedge clk); #1;
                wb_ready = 1'b1;
            end
        join
        drain();
        chk_reg(3'd6, 32'd15);
        chk_reg(3'd7, 32'd7);
        chk_reg(3'd1, 32'h107);

        // Reserved op produces no result; write to r0 handshakes but is discarded.
        @(posedge clk); #1;
        issue(3'b100, 3'd5, 3'd0, 3'd0, 1'b1, 32'h55, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("reserved_no_wb", {31'h0, wb_valid}, 32'h0);
        @(posedge clk); #1;
        issue(3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 32'd7, 32'd7);
        drain();
        chk_reg(3'd0, 32'h0);
        chk_reg(3'd5, 32'h0F0F_0F0F);

        // Reset asserted with EX and WB both occupied.
        @(posedge clk); #1;
        wb_ready = 1'b0;
        issue(3'b000, 3'd2, 3'd0, 3'd0, 1'b1, 32'd9, 32'd9);
        issue(3'b000, 3'd3, 3'd0, 3'd0, 1'b1, 32'd1, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs();
        wb_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Recovery after reset: r1 is zero again.
        issue(3'b000, 3'd2, 3'd1, 3'd0, 1'b1, 32'd4, 32'd4);
        drain();
        chk_reg(3'd2, 32'd4);
        chk_reg(3'd1, 32'h0);

        chk("sb_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
